multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Op  in  6  opcode from instruction register, stable after IRWrite.
REQ-005 SHALL have port: Zero  in  1  ALU zero flag.
REQ-006 SHALL have port: mem_ready  in  1  memory access completes in the cycle it is high.
REQ-007 SHALL have port: PCEn  out  1  PC load enable, = PCWrite | (Branch & Zero).
REQ-008 SHALL have ports: IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath strobes and selects.
REQ-009 SHALL have ports: ALUSrcB, ALUOp, PCSource  out  2 each  mux selects; ALUOp drives the ALU control unit.
REQ-010 SHALL have port: illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-011 SHALL have port: state  out  4  current state code, for debug.

Function
REQ-012 SHALL be an FSM with state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-013 SHALL drive outputs combinationally from state, plus mem_ready/Zero where listed; any output not listed for a state SHALL be 0.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; when mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE; else hold in FETCH with IRWrite=PCWrite=0.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by Op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP (REQ-028); any other Op: illegal_op=1 this cycle, go to FETCH.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Op=100011->MEMRD, else MEMWR.
REQ-017 MEMRD: MemRead=1, IorD=1; mem_ready=1->MEMWB, else hold.
REQ-018 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1; mem_ready=1->FETCH, else hold with MemWrite still asserted.
REQ-020 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; ->ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, Branch=1; ->FETCH; PCEn=1 only when Zero=1.
REQ-022 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; ->FETCH.
REQ-023 JUMP: PCSource=10, PCWrite=1; ->FETCH.
REQ-024 Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each cycle mem_ready=0 in FETCH/MEMRD/MEMWR SHALL add exactly one cycle.
REQ-025 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite SHALL never be 1 in FETCH or DECODE.

Reset
REQ-026 reset=1 SHALL immediately force state=FETCH, asynchronously and independent of clk; this applies mid-instruction, including during a wait in MEMRD/MEMWR.
REQ-027 While reset=1, all outputs except the FETCH-state MemRead/select values SHALL be 0, with IRWrite=PCEn=0 regardless of mem_ready; execution SHALL resume at the first rising edge after reset falls.

Configuration
REQ-028 Macro JUMP_SUPPORT_EN: if defined, Op=000010 in DECODE SHALL go to JUMP; if undefined, JUMP SHALL not exist and Op=000010 SHALL be treated as illegal (illegal_op=1, ->FETCH).

Verification
REQ-029 Stimulus: reset pulse, then lw (Op=100011) with mem_ready=1. Response: states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-030 Stimulus: sw (Op=101011) with mem_ready low for 3 cycles in MEMWR. Response: MemWrite=1 for 4 cycles, then FETCH.
REQ-031 Stimulus: beq (Op=000100) with Zero=1, then with Zero=0. Response: PCEn=1 with PCSource=01 in BRANCH; then PCEn=0.
REQ-032 Stimulus: R-type (Op=000000). Response: ALUOp=10 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB; 4 cycles total.
REQ-033 Stimulus: Op=000010 built with and without JUMP_SUPPORT_EN; Op=111111. Response: with the macro, JUMP with PCWrite=1 and PCSource=10; without it, illegal_op pulse; Op=111111 always gives an illegal_op pulse.
REQ-034 Stimulus: reset asserted mid-MEMRD between clock edges. Response: state=0 and MemRead IorD=0 before the next edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: decodes Op into datapath strobes/selects per state.
// Build option: define JUMP_SUPPORT_EN to add the JUMP state for Op=000010 (otherwise it is illegal).
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    // state   | meaning
    // FETCH   | read instruction, PC+4 when memory ready
    // DECODE  | register read, branch target compute, dispatch on Op
    // MEMADR  | base + offset address for lw/sw
    // MEMRD   | data memory read, waits on mem_ready
    // MEMWB   | write loaded word to rt
    // MEMWR   | data memory write, waits on mem_ready
    // EXECUTE | R-type ALU operation
    // ALUWB   | write ALU result to rd
    // BRANCH  | beq compare, PC load on Zero
    // ADDIEX  | rs + immediate
    // ADDIWB  | write ALU result to rt
    // JUMP    | PC load from jump target (JUMP_SUPPORT_EN only)
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10
`ifdef JUMP_SUPPORT_EN
        , S_JUMP  = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef JUMP_SUPPORT_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    state_t r_state;
    state_t w_next;
    logic   w_pc_write;
    logic   w_branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSource   = 2'b00;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // reset holds the state in FETCH; the strobes must not fire meanwhile
                if (mem_ready && !reset) begin
                    IRWrite    = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
`ifdef JUMP_SUPPORT_EN
                    OP_J:         w_next = S_JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                w_next   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                w_branch = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
`ifdef JUMP_SUPPORT_EN
            S_JUMP: begin
                PCSource   = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    assign PCEn  = w_pc_write | (w_branch & Zero);
    assign state = r_state;

endmodule
